// File: rtl/mul_div_unit.sv
// Sequential signed multiply/divide unit feeding the HI, LO and Z registers.
// Multiply uses radix-2 Booth on {acc, Q, q-1}. Divide runs restoring division
// on operand magnitudes and then fixes up the signs in a single extra cycle.
// Results land on zhi/zlo only on the cycle done is high, and are held afterwards.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op_div,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] zhi,
    output logic [DATA_WIDTH-1:0] zlo
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] count_reg;
    // hi_reg is one bit wider than an operand so that Booth's acc +/- m cannot
    // overflow when m is the most negative value; in divide it holds the
    // partial remainder, which can reach twice the divisor magnitude.
    logic [DW:0]   hi_reg;
    logic [DW-1:0] lo_reg;
    logic          q1_reg;
    logic [DW:0]   m_reg;
    logic          neg_q_reg;
    logic          neg_r_reg;

    logic accept;
    logic b_zero;
    logic last_iter;

    logic [DW:0]   booth_sum;
    logic [DW:0]   booth_hi_next;
    logic [DW-1:0] booth_lo_next;
    logic [DW:0]   rem_shift;
    logic [DW:0]   rem_diff;
    logic [DW:0]   div_hi_next;
    logic [DW-1:0] div_lo_next;

    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction

    // busy is low in DONE, so a request there is taken back-to-back.
    assign accept    = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign b_zero    = (operand_b == '0);
    assign last_iter = (count_reg == CW'(DW - 1));
    assign busy      = (state_reg == S_MUL) || (state_reg == S_DIV) || (state_reg == S_FIX);
    assign done      = (state_reg == S_DONE);

    // One Booth step: add/subtract m from acc, then arithmetic shift {acc, Q, q-1}.
    always_comb begin
        booth_sum = hi_reg;
        case ({lo_reg[0], q1_reg})
            2'b01:   booth_sum = hi_reg + m_reg;
            2'b10:   booth_sum = hi_reg - m_reg;
            default: booth_sum = hi_reg;
        endcase
        booth_hi_next = {booth_sum[DW], booth_sum[DW:1]};
        booth_lo_next = {booth_sum[0], lo_reg[DW-1:1]};
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract.
    always_comb begin
        rem_shift = {hi_reg[DW-1:0], lo_reg[DW-1]};
        rem_diff  = rem_shift - m_reg;
        if (rem_diff[DW]) begin
            div_hi_next = rem_shift;
            div_lo_next = {lo_reg[DW-2:0], 1'b0};
        end else begin
            div_hi_next = rem_diff;
            div_lo_next = {lo_reg[DW-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (clear) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (start) begin
                    if (!op_div)     state_next = S_MUL;
                    else if (b_zero) state_next = S_DONE;
                    else             state_next = S_DIV;
                end
            end
            S_MUL:   if (last_iter) state_next = S_DONE;
            S_DIV:   if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            q1_reg      <= 1'b0;
            m_reg       <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            div_by_zero <= 1'b0;
            zhi         <= '0;
            zlo         <= '0;
        end else if (accept) begin
            count_reg   <= '0;
            hi_reg      <= '0;
            q1_reg      <= 1'b0;
            div_by_zero <= op_div && b_zero;
            if (!op_div) begin
                lo_reg <= operand_b;
                m_reg  <= {operand_a[DW-1], operand_a};
            end else if (b_zero) begin
                zhi <= operand_a;
                zlo <= '1;
            end else begin
                lo_reg    <= magnitude(operand_a);
                m_reg     <= {1'b0, magnitude(operand_b)};
                neg_q_reg <= operand_a[DW-1] ^ operand_b[DW-1];
                neg_r_reg <= operand_a[DW-1];
            end
        end else begin
            case (state_reg)
                S_MUL: begin
                    hi_reg    <= booth_hi_next;
                    lo_reg    <= booth_lo_next;
                    q1_reg    <= lo_reg[0];
                    count_reg <= count_reg + CW'(1);
                    if (last_iter) begin
                        zhi <= booth_hi_next[DW-1:0];
                        zlo <= booth_lo_next;
                    end
                end
                S_DIV: begin
                    hi_reg    <= div_hi_next;
                    lo_reg    <= div_lo_next;
                    count_reg <= count_reg + CW'(1);
                end
                S_FIX: begin
                    zlo <= neg_q_reg ? (~lo_reg + 1'b1) : lo_reg;
                    zhi <= neg_r_reg ? (~hi_reg[DW-1:0] + 1'b1) : hi_reg[DW-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: fixed vector table, hand-written corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_mul_div_unit;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] zhi, zlo;

    int n_vec = 0;
    int n_bad = 0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .op_div(op_div),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .zhi(zhi), .zlo(zlo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic (truncating division).
    task automatic model(input logic div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dbz, output int lat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dbz = 1'b0;
        if (!div) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0]; lat = 33;
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 1;
        end else begin
            q = sa / sb; r = sa % sb;
            hi = r[31:0]; lo = q[31:0]; lat = 34;
        end
    endtask

    // Called at a negedge; issues the request and returns at the negedge where
    // done is seen (or the cycle budget runs out). inject>0 pulses a stray
    // start with junk operands during that busy cycle.
    task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                          input int inject, output int lat, output logic [31:0] hi,
                          output logic [31:0] lo, output logic dbz, output logic dbz1,
                          output logic busy_ok, output logic saw_done);
        int cyc;
        start = 1'b1; op_div = div; operand_a = a; operand_b = b;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        dbz1 = div_by_zero;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == inject) begin
                start = 1'b1; op_div = ~div;
                operand_a = $urandom; operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (busy !== 1'b0) busy_ok = 1'b0;
        saw_done = (done === 1'b1);
        lat = cyc; hi = zhi; lo = zlo; dbz = div_by_zero;
    endtask

    task automatic apply(input string tag, input logic div, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz,
                         input int exp_lat, input int inject);
        int lat;
        logic [31:0] hi, lo;
        logic dbz, dbz1, busy_ok, saw_done;
        run_op(div, a, b, inject, lat, hi, lo, dbz, dbz1, busy_ok, saw_done);
        $display("%s %s a=%h b=%h -> zhi=%h zlo=%h dbz=%0d lat=%0d", tag,
                 div ? "DIV" : "MUL", a, b, hi, lo, dbz, lat);
        check({tag, " done"}, {63'd0, saw_done}, 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " zhi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " zlo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, " div_by_zero"}, {63'd0, dbz}, {63'd0, exp_dbz});
        check({tag, " dbz@cycle1"}, {63'd0, dbz1}, {63'd0, exp_dbz});
        check({tag, " busy window"}, {63'd0, busy_ok}, 64'd1);
    endtask

    vec_t tbl[$];

    initial begin
        logic [31:0] mh, ml, ra, rb, hold_hi, hold_lo;
        logic md, rdiv;
        int ml_lat;
        bit saw;

        tbl.push_back('{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33});
        tbl.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33});
        tbl.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33});
        tbl.push_back('{1'b0, 32'd0,          32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0, 33});
        tbl.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34});
        tbl.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34});
        tbl.push_back('{1'b1, 32'd7,          32'd2,          32'h0000_0001, 32'h0000_0003, 1'b0, 34});
        tbl.push_back('{1'b1, 32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1});
        tbl.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34});
        tbl.push_back('{1'b1, 32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0, 34});

        // Reset state.
        repeat (2) @(negedge clock);
        clear = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset div_by_zero", {63'd0, div_by_zero}, 64'd0);
        check("reset zhi/zlo", {zhi, zlo}, 64'd0);
        @(negedge clock);

        // Table, issued back-to-back: each request lands in the previous DONE cycle.
        foreach (tbl[i])
            apply($sformatf("tbl%0d", i), tbl[i].div, tbl[i].a, tbl[i].b,
                  tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_dbz, tbl[i].exp_lat, 0);

        // Results held after done, through idle cycles.
        hold_hi = zhi; hold_lo = zlo;
        repeat (3) @(negedge clock);
        $display("hold zhi=%h zlo=%h done=%0d", zhi, zlo, done);
        check("hold done low", {63'd0, done}, 64'd0);
        check("hold zhi/zlo", {zhi, zlo}, {32'h0000_0002, 32'h0000_000E});
        check("hold vs done value", {zhi, zlo}, {hold_hi, hold_lo});

        // Stray start at cycle 5 of DIV 100/7 is ignored.
        apply("inject", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 5);
        @(negedge clock);

        // clear at cycle 10 of a MUL: outputs zeroed, no done afterwards.
        start = 1'b1; op_div = 1'b0; operand_a = 32'd12345; operand_b = 32'd678;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        $display("clear mid-MUL busy=%0d done=%0d zhi=%h zlo=%h", busy, done, zhi, zlo);
        check("clear busy", {63'd0, busy}, 64'd0);
        check("clear done", {63'd0, done}, 64'd0);
        check("clear zhi/zlo", {zhi, zlo}, 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        check("no done after clear", {63'd0, saw}, 64'd0);
        apply("postclear", 1'b0, 32'd12345, 32'd678, 32'd0, 32'd8369910, 1'b0, 33, 0);

        // Randomized operations against the arithmetic model.
        for (int k = 0; k < 60; k++) begin
            rdiv = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            model(rdiv, ra, rb, mh, ml, md, ml_lat);
            apply($sformatf("rnd%0d", k), rdiv, ra, rb, mh, ml, md, ml_lat,
                  (k % 4 == 0) ? 3 : 0);
            if (k % 3 == 0) @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
